// File: rtl/ldpc_ber_ctrl_if.sv
// Sample-lane and decoder-side bundle of ldpc_ber_ctrl.
// Master is the BER controller; slave is the lane/decoder side.
// Pure wiring: no storage, no latency, no flow control of its own.
interface ldpc_ber_ctrl_if #(
  parameter int DATA_W  = 5,
  parameter int LANES   = 128,
  parameter int SAMPLES = 18
);
  localparam int DIM = LANES * SAMPLES;

  logic [LANES-1:0]        smp_valid;
  logic [LANES*DATA_W-1:0] smp_llr;
  logic [LANES-1:0]        smp_ready;
  logic [DIM*DATA_W-1:0]   dec_llr;
  logic                    dec_rst;
  logic                    dec_en;
  logic                    dec_term;
  logic [DIM-1:0]          dec_res;

  modport master (
    input  smp_valid, smp_llr, dec_term, dec_res,
    output smp_ready, dec_llr, dec_rst, dec_en
  );

  modport slave (
    output smp_valid, smp_llr, dec_term, dec_res,
    input  smp_ready, dec_llr, dec_rst, dec_en
  );
endinterface

// File: rtl/ldpc_ber_ctrl.sv
// BER-test controller: packs lane samples into frames, drives ldpc_core, counts bit/frame errors per SNR point.
// Latency: LOAD->DECODE 1 cycle; dec_term -> counter update DIM/CHUNK cycles; stat_valid one cycle after that.
// Backpressure: per-lane smp_ready drops once a lane has SAMPLES samples or filling is not allowed.
// Optional macro DOUBLE_BUF_EN: keep filling into the fill buffer while the decoder works on dec_llr.
module ldpc_ber_ctrl #(
  parameter int DATA_W  = 5,
  parameter int LANES   = 128,
  parameter int SAMPLES = 18,
  parameter int CHUNK   = 64,
  parameter int FRM_W   = 16,
  parameter int ERR_W   = 32,
  parameter int SNR_W   = 4,
  parameter int FRAMES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SNR_W-1:0] snr_first,
  input  logic [SNR_W-1:0] snr_last,
  ldpc_ber_ctrl_if.master  bus,
  output logic [SNR_W-1:0] snr_idx,
  output logic [ERR_W-1:0] bit_errs,
  output logic [FRM_W-1:0] frm_errs,
  output logic [FRM_W-1:0] frm_cnt,
  output logic             stat_valid,
  output logic             busy,
  output logic             done
);
  localparam int DIM    = LANES * SAMPLES;
  localparam int NCHUNK = DIM / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int FCW    = $clog2(SAMPLES + 1);
  localparam int CNT_W  = $clog2(DIM + 1);
  localparam int SUM_W  = ((ERR_W > CNT_W) ? ERR_W : CNT_W) + 1;
`ifdef DOUBLE_BUF_EN
  // dec_llr holds the frame under decode, so fbuf is free to take the next one
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LOAD, S_DECODE, S_CHECK, S_STAT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [FCW-1:0]        fill_cnt [LANES];
  logic [DATA_W-1:0]     fbuf [DIM];
  logic [DIM*DATA_W-1:0] dec_llr_q;
  logic [SNR_W-1:0]      snr_last_q;
  logic [IDX_W-1:0]      chk_idx;
  logic [CNT_W-1:0]      chk_acc;

  logic                  fill_en, all_full, clr_fill, start_ok;
  logic                  chk_last, frm_last;
  logic                  dec_rst_c, dec_en_c;
  logic [LANES-1:0]      ready, accept;
  logic [CHUNK-1:0]      chunk;
  logic [CNT_W-1:0]      chk_total;
  logic [SUM_W-1:0]      err_sum;
  logic [ERR_W-1:0]      err_sat;

  function automatic logic [CNT_W-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int b = 0; b < CHUNK; b++) c = c + CNT_W'(v[b]);
    return c;
  endfunction

  assign fill_en  = (state == S_FILL) ||
                    (DBUF && (state == S_LOAD || state == S_DECODE || state == S_CHECK));
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  // LOAD hands the frame over; STAT drops any partial frame of the finished point
  assign clr_fill = start_ok || (state == S_LOAD) || (state == S_STAT);

  assign bus.smp_ready = ready;
  assign bus.dec_llr   = dec_llr_q;
  assign bus.dec_rst   = dec_rst_c;
  assign bus.dec_en    = dec_en_c;

  // Per-lane ready/accept; all_full also counts accepts landing this cycle
  always_comb begin
    ready    = '0;
    accept   = '0;
    all_full = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      ready[i]  = fill_en && (fill_cnt[i] < FCW'(SAMPLES));
      accept[i] = ready[i] && bus.smp_valid[i];
      if ((fill_cnt[i] + FCW'(accept[i])) != FCW'(SAMPLES)) all_full = 1'b0;
    end
  end

  // Chunk popcount, running frame total and saturating error sum
  always_comb begin
    chunk = '0;
    for (int c = 0; c < NCHUNK; c++)
      if (chk_idx == IDX_W'(c)) chunk = bus.dec_res[c*CHUNK +: CHUNK];
    chk_total = chk_acc + popcnt(chunk);
    chk_last  = (chk_idx == IDX_W'(NCHUNK - 1));
    frm_last  = (frm_cnt == FRM_W'(FRAMES - 1));
    err_sum   = SUM_W'(bit_errs) + SUM_W'(chk_total);
    err_sat   = (err_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // Next-state and per-state outputs
  always_comb begin
    state_nxt  = state;
    dec_rst_c  = 1'b0;
    dec_en_c   = 1'b0;
    stat_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        dec_rst_c = 1'b1;
        if (start) state_nxt = S_FILL;
      end
      S_FILL: if (all_full) state_nxt = S_LOAD;
      S_LOAD: begin
        dec_rst_c = 1'b1;
        dec_en_c  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        dec_en_c = 1'b1;
        if (bus.dec_term) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        dec_en_c = !chk_last;
        if (chk_last) begin
          if (frm_last)      state_nxt = S_STAT;
          else if (all_full) state_nxt = S_LOAD;
          else               state_nxt = S_FILL;
        end
      end
      S_STAT: begin
        stat_valid = 1'b1;
        state_nxt  = (snr_idx == snr_last_q) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = S_FILL;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Lane fill counters; k-th sample of lane i lands at the top of its slice going down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) fill_cnt[i] <= '0;
      for (int s = 0; s < DIM; s++)   fbuf[s]     <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (clr_fill) fill_cnt[i] <= '0;
        else          fill_cnt[i] <= fill_cnt[i] + FCW'(accept[i]);
        for (int k = 0; k < SAMPLES; k++)
          if (accept[i] && fill_cnt[i] == FCW'(k))
            fbuf[i*SAMPLES + SAMPLES - 1 - k] <= bus.smp_llr[i*DATA_W +: DATA_W];
      end
    end
  end

  // Frame handed to the decoder at LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_llr_q <= '0;
    end else if (state == S_LOAD) begin
      for (int s = 0; s < DIM; s++) dec_llr_q[s*DATA_W +: DATA_W] <= fbuf[s];
    end
  end

  // Chunk walker over dec_res during CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_idx <= '0;
      chk_acc <= '0;
    end else if (state == S_CHECK) begin
      if (chk_last) begin
        chk_idx <= '0;
        chk_acc <= '0;
      end else begin
        chk_idx <= chk_idx + IDX_W'(1);
        chk_acc <= chk_total;
      end
    end
  end

  // SNR point and error statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snr_idx    <= '0;
      snr_last_q <= '0;
      bit_errs   <= '0;
      frm_errs   <= '0;
      frm_cnt    <= '0;
    end else if (start_ok) begin
      snr_idx    <= snr_first;
      snr_last_q <= snr_last;
      bit_errs   <= '0;
      frm_errs   <= '0;
      frm_cnt    <= '0;
    end else if (state == S_CHECK && chk_last) begin
      bit_errs <= err_sat;
      frm_errs <= frm_errs + FRM_W'(chk_total != '0);
      frm_cnt  <= frm_cnt + FRM_W'(1);
    end else if (state == S_STAT && snr_idx != snr_last_q) begin
      snr_idx  <= snr_idx + SNR_W'(1);
      bit_errs <= '0;
      frm_errs <= '0;
      frm_cnt  <= '0;
    end
  end
endmodule
